// File: rtl/mem_port_arbiter_if.sv
// Memory port bundle shared by the CPU requester,
// the external loader/debug requester and the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_wr;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_lock;
    logic              ext_gnt;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_dout;
    logic [1:0]        owner;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
        input  ext_req, ext_wr, ext_addr, ext_wdata, ext_lock,
        output ext_gnt, ext_rdata, ext_rvalid,
        output mem_addr, mem_din, mem_wr, owner,
        input  mem_dout
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
        output ext_req, ext_wr, ext_addr, ext_wdata, ext_lock,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  mem_addr, mem_din, mem_wr, owner,
        output mem_dout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: CPU vs external loader,
// round-robin tie-break, capped external locked bursts.
module mem_port_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_EXT = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] burst_cnt;
    logic       last_ext;
    logic [4:0] cnt_next;
    logic       burst_more;

    assign cnt_next   = {1'b0, burst_cnt} + 5'd1;
    assign burst_more = bus.ext_lock
                      && (cnt_next < 5'(BURST_MAX));

    assign bus.cpu_gnt   = (state == GNT_CPU);
    assign bus.ext_gnt   = (state == GNT_EXT);
    assign bus.owner     = {bus.ext_gnt, bus.cpu_gnt};
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_gnt;

    // Route the owning requester onto the memory bus;
    // writes are suppressed while reset is held.
    always_comb begin
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        bus.mem_wr   = 1'b0;
        unique case (state)
            GNT_CPU: begin
                bus.mem_addr = bus.cpu_addr;
                bus.mem_din  = bus.cpu_wdata;
                bus.mem_wr   = rst & bus.cpu_req & bus.cpu_wr;
            end
            GNT_EXT: begin
                bus.mem_addr = bus.ext_addr;
                bus.mem_din  = bus.ext_wdata;
                bus.mem_wr   = rst & bus.ext_req & bus.ext_wr;
            end
            default: ;
        endcase
    end

    // Grant FSM with read-data capture and burst tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            burst_cnt      <= '0;
            last_ext       <= 1'b1;
            bus.cpu_rdata  <= '0;
            bus.ext_rdata  <= '0;
            bus.cpu_rvalid <= 1'b0;
            bus.ext_rvalid <= 1'b0;
        end else begin
            bus.cpu_rvalid <= 1'b0;
            bus.ext_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cpu_req && (!bus.ext_req || last_ext))
                        state <= GNT_CPU;
                    else if (bus.ext_req)
                        state <= GNT_EXT;
                end
                GNT_CPU: begin
                    state <= IDLE;
                    if (bus.cpu_req) begin
                        last_ext <= 1'b0;
                        if (!bus.cpu_wr) begin
                            bus.cpu_rdata  <= bus.mem_dout;
                            bus.cpu_rvalid <= 1'b1;
                        end
                    end
                end
                GNT_EXT: begin
                    if (bus.ext_req) begin
                        if (!bus.ext_wr) begin
                            bus.ext_rdata  <= bus.mem_dout;
                            bus.ext_rvalid <= 1'b1;
                        end
                        if (burst_more) begin
                            burst_cnt <= cnt_next[3:0];
                        end else begin
                            state     <= IDLE;
                            burst_cnt <= '0;
                            last_ext  <= 1'b1;
                        end
                    end else begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
